// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, handshake FSM states and
// the WIDTH+1-bit add/subtract helper.
package alu_pkg;

    // Widest operand the add/sub helper supports; callers zero-extend into it.
    localparam int MAX_W = 64;

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_AND    = 5'b00001;
    localparam logic [4:0] OP_PASS_A = 5'b00010;
    localparam logic [4:0] OP_PASS_B = 5'b00011;
    localparam logic [4:0] OP_OR     = 5'b00100;
    localparam logic [4:0] OP_XOR    = 5'b00101;
    localparam logic [4:0] OP_SHL    = 5'b00110;
    localparam logic [4:0] OP_SHR    = 5'b00111;
    localparam logic [4:0] OP_SUB    = 5'b01100;
    localparam logic [4:0] OP_INC    = 5'b10100;
    localparam logic [4:0] OP_DEC    = 5'b10101;
    localparam logic [4:0] OP_MUL    = 5'b11000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } alu_state_e;

    // With zero-extended operands, bit WIDTH of the result is the carry for an
    // add and the borrow for a subtract, whatever WIDTH the caller uses.
    function automatic logic [MAX_W:0] add_sub(input logic [MAX_W-1:0] x,
                                               input logic [MAX_W-1:0] y,
                                               input logic             sub);
        if (sub)
            return {1'b0, x} - {1'b0, y};
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start; done is raised during the final iteration.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic               running;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [CW-1:0]      count;

    // product is the accumulator after this cycle's iteration, so the owner can
    // capture the final value on the same edge that retires the last step.
    always_comb begin
        addend = '0;
        if (mplier[0])
            addend = {{WIDTH{1'b0}}, mcand} << count;
        product = acc + addend;
        done    = running && (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            mcand   <= mcand_in;
            mplier  <= mplier_in;
            acc     <= '0;
            count   <= '0;
        end else if (running) begin
            acc    <= product;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops finish in one
// cycle, MUL runs through alu_mul_iter and finishes WIDTH+1 cycles after accept.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on valid, and a held result stays stable.
    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [MAX_W:0]     sum_full;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     sh_l;
    logic [WIDTH:0]     sh_r;
    logic [WIDTH-1:0]   opnd;
    logic [SHW-1:0]     amt;
    logic               sub;
    logic [WIDTH-1:0]   c_res;
    logic               c_carry;
    logic               c_ovf;
    logic               c_illegal;
    logic               unused_sum_hi;

    assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign state_dbg = state;

    always_comb begin
        amt       = b[SHW-1:0];
        opnd      = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
        sub       = (op == OP_SUB) || (op == OP_DEC);
        sum_full  = add_sub(MAX_W'(a), MAX_W'(opnd), sub);
        sum       = sum_full[WIDTH:0];
        sh_l      = {1'b0, a} << amt;
        sh_r      = {a, 1'b0} >> amt;
        c_res     = '0;
        c_carry   = 1'b0;
        c_ovf     = 1'b0;
        c_illegal = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                c_res   = sum[WIDTH-1:0];
                c_carry = sum[WIDTH];
                c_ovf   = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                c_res   = sum[WIDTH-1:0];
                c_carry = sum[WIDTH];
                c_ovf   = (a[WIDTH-1] != opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:    c_res = a & b;
            OP_OR:     c_res = a | b;
            OP_XOR:    c_res = a ^ b;
            OP_PASS_A: c_res = a;
            OP_PASS_B: c_res = b;
            // The extra bit beside the shifted word catches the last bit out.
            OP_SHL: begin
                c_res   = sh_l[WIDTH-1:0];
                c_carry = sh_l[WIDTH];
            end
            OP_SHR: begin
                c_res   = sh_r[WIDTH:1];
                c_carry = sh_r[0];
            end
            OP_MUL:    c_res = '0;
            default:   c_illegal = 1'b1;
        endcase
    end

    assign unused_sum_hi = ^sum_full[MAX_W:WIDTH+1];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .mcand_in  (a),
        .mplier_in (b),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state <= MUL_BUSY;
                        end else begin
                            state   <= DONE;
                            result  <= c_res;
                            carry   <= c_carry;
                            zero    <= (c_res == '0);
                            neg     <= c_res[WIDTH-1];
                            ovf     <= c_ovf;
                            illegal <= c_illegal;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        state   <= DONE;
                        result  <= mul_product[WIDTH-1:0];
                        carry   <= |mul_product[2*WIDTH-1:WIDTH];
                        zero    <= (mul_product[WIDTH-1:0] == '0);
                        neg     <= mul_product[WIDTH-1];
                        ovf     <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed cases, a reset-mid-MUL case and randomized
// traffic checked against an arithmetic reference model through an expected queue.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int RW = W + 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [4:0]   op;
    logic         carry, zero, neg, ovf, illegal;
    logic [1:0]   state_dbg;

    logic         in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [15:0]  a_w, b_w, result_w;
    logic [4:0]   op_w;
    logic         carry_w, zero_w, neg_w, ovf_w, illegal_w;
    logic [1:0]   state_dbg_w;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 0;
    bit rand_ready = 0;
    bit shown = 0;

    logic [RW-1:0] exp_q[$];
    int            acc_q[$];
    int            lat_q[$];

    logic [4:0] ops[12] = '{OP_ADD, OP_AND, OP_PASS_A, OP_PASS_B, OP_OR, OP_XOR,
                            OP_SHL, OP_SHR, OP_SUB, OP_INC, OP_DEC, OP_MUL};

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf),
        .illegal(illegal), .state_dbg(state_dbg)
    );

    alu_pipe #(.WIDTH(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .op(op_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .result(result_w), .carry(carry_w), .zero(zero_w), .neg(neg_w), .ovf(ovf_w),
        .illegal(illegal_w), .state_dbg(state_dbg_w)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] pk(input logic [W-1:0] r, input logic c, input logic z,
                                         input logic n, input logic o, input logic il);
        return {il, o, n, z, c, r};
    endfunction

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference model: plain integer arithmetic on an 8-bit datapath.
    function automatic logic [RW-1:0] model(input logic [4:0] o, input int x, input int y);
        int r, c, ov, il, amt, s;
        logic [W-1:0] rr;
        r = 0; c = 0; ov = 0; il = 0; s = 0;
        amt = y % 8;
        case (o)
            OP_ADD:    begin r = x + y; c = (r > 255);  s = sgn(x) + sgn(y); ov = (s > 127) || (s < -128); end
            OP_SUB:    begin r = x - y; c = (x < y);    s = sgn(x) - sgn(y); ov = (s > 127) || (s < -128); end
            OP_INC:    begin r = x + 1; c = (x == 255); ov = (sgn(x) + 1 > 127); end
            OP_DEC:    begin r = x - 1; c = (x == 0);   ov = (sgn(x) - 1 < -128); end
            OP_AND:    r = x & y;
            OP_OR:     r = x | y;
            OP_XOR:    r = x ^ y;
            OP_PASS_A: r = x;
            OP_PASS_B: r = y;
            OP_SHL:    begin r = x << amt; c = (amt != 0) ? (x >> (8 - amt)) & 1 : 0; end
            OP_SHR:    begin r = x >> amt; c = (amt != 0) ? (x >> (amt - 1)) & 1 : 0; end
            OP_MUL:    begin r = x * y; c = (r > 255); end
            default:   il = 1;
        endcase
        rr = 8'(r);
        return pk(rr, c != 0, rr == 0, rr[7], ov != 0, il != 0);
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic e_rdy;
        if (rst_n && mon_en) begin
            if (exp_q.size() == 0) e_rdy = 1'b1;
            else if (out_valid)    e_rdy = out_ready;
            else                   e_rdy = 1'b0;
            check("in_ready", in_ready, e_rdy);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    if (!shown) begin
                        check("latency", cyc - acc_q[0], lat_q[0]);
                        shown = 1;
                    end
                    check("result_flags", pk(result, carry, zero, neg, ovf, illegal), exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        void'(lat_q.pop_front());
                        shown = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, a, b));
                acc_q.push_back(cyc);
                lat_q.push_back((op == OP_MUL) ? W + 1 : 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok;
        ok = 0;
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 5'($urandom);
        check("accept", ok, 1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size() == 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        in_valid_w = 1'b0; out_ready_w = 1'b1; a_w = '0; b_w = '0; op_w = '0;

        // Hand-computed values pinning the reference model.
        check("pin_add", model(OP_ADD, 8'hFF, 8'h01), pk(8'h00, 1, 1, 0, 0, 0));
        check("pin_sub", model(OP_SUB, 8'h80, 8'h01), pk(8'h7F, 0, 0, 0, 1, 0));
        check("pin_inc", model(OP_INC, 8'h7F, 8'h00), pk(8'h80, 0, 0, 1, 1, 0));
        check("pin_dec", model(OP_DEC, 8'h00, 8'h00), pk(8'hFF, 1, 0, 1, 0, 0));
        check("pin_mul_ovf", model(OP_MUL, 16, 17), pk(8'h10, 1, 0, 0, 0, 0));
        check("pin_mul", model(OP_MUL, 3, 5), pk(8'h0F, 0, 0, 0, 0, 0));
        check("pin_shl", model(OP_SHL, 8'h81, 8'd1), pk(8'h02, 1, 0, 0, 0, 0));
        check("pin_shr", model(OP_SHR, 8'h01, 8'd0), pk(8'h01, 0, 0, 0, 0, 0));
        check("pin_illegal", model(5'b11111, 8'h12, 8'h34), pk(8'h00, 0, 1, 0, 0, 1));

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, in_ready, result, carry, zero, neg, ovf, illegal}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;
        mon_en = 1;

        // Back-to-back single-cycle ops, then MULs and an illegal opcode.
        send(OP_ADD, 8'hFF, 8'h01);
        send(OP_SUB, 8'h80, 8'h01);
        send(OP_INC, 8'h7F, 8'h00);
        send(OP_DEC, 8'h00, 8'h00);
        send(OP_MUL, 8'd16, 8'd17);
        send(OP_MUL, 8'd3, 8'd5);
        send(5'b11111, 8'h55, 8'hAA);
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(OP_SHL, 8'h81, 8'd1);
        idle(5);
        out_ready = 1'b1;
        send(OP_SHR, 8'h01, 8'd0);
        drain();

        // Reset in the middle of a MUL aborts it.
        send(OP_MUL, 8'hFF, 8'hFF);
        idle(1);
        rst_n = 1'b0;
        mon_en = 0;
        exp_q.delete(); acc_q.delete(); lat_q.delete(); shown = 0;
        #1;
        check("midmul_reset_outputs", {out_valid, in_ready, result, carry, zero, neg, ovf, illegal}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1;
        @(negedge clk);
        check("midmul_ready_after", in_ready, 1);
        @(posedge clk);
        #1;
        idle(12);

        // Randomized traffic with random consumer backpressure.
        rand_ready = 1;
        for (int k = 0; k < 300; k++) begin
            logic [4:0] o;
            if ($urandom_range(0, 7) == 0) o = 5'($urandom);
            else                           o = ops[$urandom_range(0, 11)];
            send(o, pick(), pick());
            idle($urandom_range(0, 2));
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // 16-bit instance: carry out of the wider adder.
        mon_en = 0;
        a_w = 16'hFFFF; b_w = 16'h0001; op_w = OP_ADD; in_valid_w = 1'b1;
        @(negedge clk);
        check("w16_ready", in_ready_w, 1);
        @(posedge clk);
        #1;
        in_valid_w = 1'b0;
        @(negedge clk);
        check("w16_valid", out_valid_w, 1);
        check("w16_result", result_w, 16'h0000);
        check("w16_flags", {carry_w, zero_w, neg_w, ovf_w, illegal_w}, 5'b11000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
